// File: rtl/exec_pkg.sv
// Shared definitions for the sequenced execution unit:
// opcodes, FSM state encoding and flag bit positions.
package exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_PSA  = 4'd8;
  localparam logic [3:0] OP_PSB  = 4'd9;
  localparam logic [3:0] OP_INC  = 4'd10;
  localparam logic [3:0] OP_DEC  = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_EXEC,
    ST_WB
  } state_t;

  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/exec_mem.sv
// Word memory: one synchronous read port, one write port
// shared between host loads and operation writeback.
module exec_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the pre-write contents on an address clash.
  always_ff @(posedge clk) begin
    if (wb_en) begin
      mem[wb_addr] <= wb_data;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/exec_unit_seq.sv
// Sequenced execution unit: read A, read B, execute,
// write back, with a start/done handshake.
module exec_unit_seq
  import exec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] out,
  output logic [3:0]        flag
);

  localparam int M = DATA_W - 1;

  state_t state, state_nx;

  logic [3:0]        op_q;
  logic [ADDR_W-1:0] a1_q, a2_q, a3_q;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              ld_ok, wb_en;

  logic [DATA_W-1:0] opb, alu_r;
  logic [DATA_W:0]   sum;
  logic [3:0]        alu_f;
  logic              alu_c, alu_v;

  assign ld_ok = ld_en && !rst && state == ST_IDLE;
  assign wb_en = !rst && state == ST_WB;
  assign raddr = (state == ST_RD_A) ? a1_q : a2_q;

  exec_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .ld_en   (ld_ok),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .wb_en   (wb_en),
    .wb_addr (a3_q),
    .wb_data (out),
    .raddr   (raddr),
    .rdata   (rdata)
  );

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ST_RD_A;
      end
      ST_RD_A: state_nx = ST_RD_B;
      ST_RD_B: state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_WB;
      ST_WB: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand B comes straight off the read port during EXEC.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    sum   = '0;
    opb   = rdata;
    if (op_q == OP_INC || op_q == OP_DEC)
      opb = {{(DATA_W-1){1'b0}}, 1'b1};
    case (op_q)
      OP_ADD, OP_INC: begin
        sum   = {1'b0, a} + {1'b0, opb};
        alu_r = sum[M:0];
        alu_c = sum[DATA_W];
        alu_v = (a[M] == opb[M]) && (alu_r[M] != a[M]);
      end
      OP_SUB, OP_DEC: begin
        sum   = {1'b0, a} - {1'b0, opb};
        alu_r = sum[M:0];
        alu_c = sum[DATA_W];
        alu_v = (a[M] != opb[M]) && (alu_r[M] != a[M]);
      end
      OP_AND: alu_r = a & rdata;
      OP_OR:  alu_r = a | rdata;
      OP_XOR: alu_r = a ^ rdata;
      OP_NOT: alu_r = ~a;
      OP_SHL: begin
        alu_r = {a[M-1:0], 1'b0};
        alu_c = a[M];
      end
      OP_SHR: begin
        alu_r = {1'b0, a[M:1]};
        alu_c = a[0];
      end
      OP_PSA: alu_r = a;
      OP_PSB: alu_r = rdata;
      default: alu_r = '0;
    endcase
    alu_f        = '0;
    alu_f[FLG_C] = alu_c;
    alu_f[FLG_Z] = (alu_r == '0);
    alu_f[FLG_N] = alu_r[M];
    alu_f[FLG_V] = alu_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q  <= '0;
      a1_q  <= '0;
      a2_q  <= '0;
      a3_q  <= '0;
      a     <= '0;
      b     <= '0;
      out   <= '0;
      flag  <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        op_q <= opcode;
        a1_q <= addr1;
        a2_q <= addr2;
        a3_q <= addr3;
      end
      if (state == ST_RD_B) a <= rdata;
      if (state == ST_EXEC) begin
        b    <= rdata;
        out  <= alu_r;
        flag <= alu_f;
      end
    end
  end

endmodule

// File: tb/tb_exec_unit_seq.sv
// Bench for exec_unit_seq: transaction-level model checked
// every cycle, plus directed operations with literal results.
module tb_exec_unit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [4:0]  addr1 = '0, addr2 = '0, addr3 = '0;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        busy, done;
  logic [15:0] a, b, out;
  logic [3:0]  flag;

  int n_chk = 0;
  int n_fail = 0;

  exec_unit_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .opcode  (opcode),
    .addr1   (addr1),
    .addr2   (addr2),
    .addr3   (addr3),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .busy    (busy),
    .done    (done),
    .a       (a),
    .b       (b),
    .out     (out),
    .flag    (flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic.
  task automatic alu_m(input logic [3:0] op,
                       input logic [15:0] x,
                       input logic [15:0] y,
                       output logic [15:0] r,
                       output logic [3:0] f);
    int ux, uy, sx, sy, t, s;
    bit c, v;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    c = 0;
    v = 0;
    r = 16'h0;
    if (op == 4'd10 || op == 4'd11) begin
      uy = 1;
      sy = 1;
    end
    case (op)
      4'd0, 4'd10: begin
        t = ux + uy;
        r = t[15:0];
        c = t > 65535;
        s = sx + sy;
        v = s > 32767 || s < -32768;
      end
      4'd1, 4'd11: begin
        t = ux - uy;
        r = t[15:0];
        c = ux < uy;
        s = sx - sy;
        v = s > 32767 || s < -32768;
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ~x;
      4'd6: begin
        t = ux * 2;
        r = t[15:0];
        c = ux >= 32768;
      end
      4'd7: begin
        r = 16'(ux / 2);
        c = (ux % 2) == 1;
      end
      4'd8: r = x;
      4'd9: r = y;
      default: r = 16'h0;
    endcase
    f = {c, r == 16'h0, r[15], v};
  endtask

  logic [15:0] m [32];
  int          ph = 0;
  logic [3:0]  mop;
  logic [15:0] ma, mb;
  logic [4:0]  md;
  logic [15:0] ea = '0, eb = '0, eo = '0;
  logic [3:0]  ef = '0;

  // Transaction timeline: accept, read A, read B, execute, write back.
  always @(posedge clk) begin
    if (rst) begin
      ph = 0;
      ea = '0;
      eb = '0;
      eo = '0;
      ef = '0;
    end else begin
      case (ph)
        0: begin
          if (ld_en) m[ld_addr] = ld_data;
          if (start) begin
            mop = opcode;
            ma  = m[addr1];
            mb  = m[addr2];
            md  = addr3;
            ph  = 1;
          end
        end
        1: ph = 2;
        2: begin
          ea = ma;
          ph = 3;
        end
        3: begin
          eb = mb;
          alu_m(mop, ma, mb, eo, ef);
          ph = 4;
        end
        default: begin
          m[md] = eo;
          ph = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy", {15'h0, busy}, {15'h0, ph != 0});
    chk("done", {15'h0, done}, {15'h0, ph == 4});
    chk("a", a, ea);
    chk("b", b, eb);
    chk("out", out, eo);
    chk("flag", {12'h0, flag}, {12'h0, ef});
  end

  task automatic load(input logic [4:0] ad,
                      input logic [15:0] d);
    @(negedge clk);
    #1;
    ld_en = 1'b1;
    ld_addr = ad;
    ld_data = d;
    @(negedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic run_op(input string nm,
                        input logic [3:0] op,
                        input logic [4:0] x,
                        input logic [4:0] y,
                        input logic [4:0] d,
                        input logic [15:0] xo,
                        input logic [3:0] xf,
                        input bit ld,
                        input logic [4:0] la,
                        input logic [15:0] lv);
    int lat;
    lat = 0;
    @(negedge clk);
    #1;
    start = 1'b1;
    opcode = op;
    addr1 = x;
    addr2 = y;
    addr3 = d;
    ld_en = ld;
    ld_addr = la;
    ld_data = lv;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        chk({nm, " out"}, out, xo);
        chk({nm, " flag"}, {12'h0, flag}, {12'h0, xf});
      end
      #1;
      start = 1'b0;
      ld_en = 1'b0;
      if (lat != 0) break;
    end
    chk({nm, " latency"}, 16'(lat), 16'd4);
  endtask

  int n_busy, n_done;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;

    load(5'd1, 16'h7FFF);
    load(5'd2, 16'h0001);
    run_op("add_ovf", 4'd0, 5'd1, 5'd2, 5'd3,
           16'h8000, 4'b0011, 0, 5'd0, 16'h0);
    run_op("pass_wb", 4'd8, 5'd3, 5'd2, 5'd13,
           16'h8000, 4'b0010, 0, 5'd0, 16'h0);

    load(5'd4, 16'hFFFF);
    load(5'd5, 16'h0001);
    run_op("add_carry", 4'd0, 5'd4, 5'd5, 5'd14,
           16'h0000, 4'b1100, 0, 5'd0, 16'h0);
    load(5'd6, 16'h0005);
    load(5'd7, 16'h0005);
    run_op("sub_zero", 4'd1, 5'd6, 5'd7, 5'd15,
           16'h0000, 4'b0100, 0, 5'd0, 16'h0);
    load(5'd8, 16'h0003);
    load(5'd9, 16'h0005);
    run_op("sub_borrow", 4'd1, 5'd8, 5'd9, 5'd16,
           16'hFFFE, 4'b1010, 0, 5'd0, 16'h0);
    load(5'd17, 16'h8001);
    run_op("shl", 4'd6, 5'd17, 5'd17, 5'd18,
           16'h0002, 4'b1000, 0, 5'd0, 16'h0);
    run_op("shr", 4'd7, 5'd17, 5'd17, 5'd23,
           16'h4000, 4'b1000, 0, 5'd0, 16'h0);
    run_op("inc", 4'd10, 5'd1, 5'd1, 5'd24,
           16'h8000, 4'b0011, 0, 5'd0, 16'h0);
    run_op("dec", 4'd11, 5'd5, 5'd5, 5'd25,
           16'h0000, 4'b0100, 0, 5'd0, 16'h0);
    run_op("xor", 4'd4, 5'd1, 5'd4, 5'd26,
           16'h8000, 4'b0010, 0, 5'd0, 16'h0);

    // Stray starts in RD_B and WB, host load while busy.
    n_busy = 0;
    n_done = 0;
    @(negedge clk);
    #1;
    start = 1'b1;
    opcode = 4'd0;
    addr1 = 5'd1;
    addr2 = 5'd2;
    addr3 = 5'd19;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_busy += int'(busy);
      n_done += int'(done);
      #1;
      start = (i == 2 || i == 4);
      opcode = 4'd8;
      addr1 = 5'd5;
      addr3 = 5'd22;
      ld_en = (i == 3);
      ld_addr = 5'd1;
      ld_data = 16'h0000;
    end
    start = 1'b0;
    ld_en = 1'b0;
    chk("busy_cycles", 16'(n_busy), 16'd4);
    chk("done_pulses", 16'(n_done), 16'd1);
    run_op("mem_kept", 4'd8, 5'd1, 5'd2, 5'd27,
           16'h7FFF, 4'b0000, 0, 5'd0, 16'h0);

    // Reset during EXEC must abort the writeback.
    load(5'd10, 16'h1234);
    load(5'd20, 16'h0F0F);
    @(negedge clk);
    #1;
    start = 1'b1;
    opcode = 4'd0;
    addr1 = 5'd20;
    addr2 = 5'd20;
    addr3 = 5'd10;
    @(negedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_a", a, 16'h0);
    chk("rst_out", out, 16'h0);
    chk("rst_flag", {12'h0, flag}, 16'h0);
    #1;
    rst = 1'b0;
    run_op("no_wb", 4'd8, 5'd10, 5'd10, 5'd28,
           16'h1234, 4'b0000, 0, 5'd0, 16'h0);

    run_op("ld_start", 4'd8, 5'd11, 5'd11, 5'd21,
           16'h00AA, 4'b0000, 1, 5'd11, 16'h00AA);
    load(5'd12, 16'h5555);
    run_op("rsvd", 4'd13, 5'd11, 5'd11, 5'd12,
           16'h0000, 4'b0100, 0, 5'd0, 16'h0);
    run_op("rsvd_wb", 4'd8, 5'd12, 5'd11, 5'd29,
           16'h0000, 4'b0100, 0, 5'd0, 16'h0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/exec_unit_seq.md
Name: exec_unit_seq

Overview:
Sequenced, parametrised execution unit with a start/done handshake.
- Reads two operands from internal word memory at addr1 and addr2.
- Applies a 4-bit ALU opcode.
- Registers result and flags, then writes the result back to addr3.
- Sits between the instruction sequencer and the data store; a host load port preloads memory.

Parameters:
DATA_W, 16, operand/result/memory word width (>=4)
ADDR_W, 5, memory address width
DEPTH, 32, memory words; must equal 2**ADDR_W

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  request one operation; sampled only in IDLE
opcode  in  4  ALU operation, latched on accepted start
addr1  in  ADDR_W  operand A address, latched on accepted start
addr2  in  ADDR_W  operand B address, latched on accepted start
addr3  in  ADDR_W  destination address, latched on accepted start
ld_en  in  1  host write strobe; honoured only in IDLE
ld_addr  in  ADDR_W  host write address
ld_data  in  DATA_W  host write data
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse in WB cycle
a  out  DATA_W  registered operand A
b  out  DATA_W  registered operand B
out  out  DATA_W  registered ALU result
flag  out  4  registered flags: [3]=C, [2]=Z, [1]=N, [0]=V

Behaviour:
- Reset: state=IDLE; busy=0, done=0, a=0, b=0, out=0, flag=0. Memory contents are not reset and are undefined until written.
- Memory has one synchronous read port (1-cycle latency) and one write port. Writes are not visible on a read in the same cycle.
- FSM IDLE->RD_A->RD_B->EXEC->WB->IDLE, one cycle per state:
  - IDLE: start=1 latches opcode/addr1/addr2/addr3 and moves to RD_A.
  - RD_A: drive read address addr1.
  - RD_B: a<=rdata; drive read address addr2.
  - EXEC: b<=rdata; out<=ALU(a, rdata); flag<=flags(a, rdata).
  - WB: mem[addr3]<=out; done=1.
- Latency: start sampled at edge T gives done high during cycle T+4. Back-to-back starts are accepted every 5 cycles at best.
- start while busy (including WB) is ignored, not queued.
- ld_en in IDLE writes mem[ld_addr]<=ld_data. ld_en while busy is ignored.
- ld_en and start together in IDLE: the load commits first, so the operation reads the newly loaded value if addresses match.
- addr3 equal to addr1 or addr2 is legal; operands are read before writeback.
- Reset asserted mid-operation: abort immediately, no writeback, all outputs return to reset values.
- ALU is DATA_W-bit, modulo 2**DATA_W:
  - 0 ADD a+b; C=carry out; V=signed overflow.
  - 1 SUB a-b; C=borrow (1 when a<b unsigned); V=signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT a.
  - 6 SHL a by 1; C=a[MSB].
  - 7 SHR logical a by 1; C=a[0].
  - 8 PASS a, 9 PASS b.
  - 10 INC a, 11 DEC a; C and V as for ADD/SUB with b=1.
  - 12-15 reserved: result 0, writeback still performed.
- Flags:
  - Z=(result==0) and N=result[MSB] for all opcodes.
  - C and V are 0 wherever not defined above.
- a, b, out, flag hold their values until the next EXEC or reset.

Decomposition:
- Shared package exec_pkg holds:
  - opcode localparams (OP_ADD..OP_DEC);
  - state encoding (ST_IDLE, ST_RD_A, ST_RD_B, ST_EXEC, ST_WB);
  - flag bit indices (FLG_C, FLG_Z, FLG_N, FLG_V).
- One sub-module, exec_mem: parametrised DATA_W/ADDR_W, sync read, single write port; write mux selects host or writeback.
- ALU stays a combinational function/block inside exec_unit_seq.

Test Plan:
- Load mem[1]=0x7FFF, mem[2]=0x0001; start ADD, addr1=1, addr2=2, addr3=3 -> done at T+4, out=0x8000, flag=C0 Z0 N1 V1 (0b0011); subsequent PASS a from addr 3 returns 0x8000.
- mem[4]=0xFFFF, mem[5]=0x0001, ADD -> out=0x0000, flag=C1 Z1 N0 V0 (0b1100); then SUB 5-5 with mem[6]=5, mem[7]=5 -> out=0, Z=1, C=0.
- SUB with mem[8]=0x0003, mem[9]=0x0005 -> out=0xFFFE, C=1, N=1; SHL on 0x8001 -> out=0x0002, C=1.
- Start pulsed in RD_B and WB of a running op -> ignored; exactly one done pulse; busy high for 4 cycles; ld_en during busy does not alter memory.
- Reset asserted during EXEC with addr3=10 preloaded to 0x1234 -> outputs zero next cycle, mem[10] still 0x1234, FSM accepts a fresh start.
- ld_en (addr 11, data 0x00AA) and start PASS a from addr 11 in the same IDLE cycle -> out=0x00AA; opcode 13 -> out=0, flag Z=1, destination written with 0.
